// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator: one shared frame counter, per-channel
// angle targets written over a valid/ready port, slew-limited ramps applied on frame boundaries.
module servo_pwm_multi #(
    parameter int NUM_CH      = 4,
    parameter int PERIOD_CLKS = 1000000,
    parameter int MIN_CLKS    = 25000,
    parameter int STEP_CLKS   = 555,
    parameter int SLEW_CLKS   = 5550,
    parameter int INIT_ANGLE  = 90
) (
    input  logic              mclk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_ch,
    input  logic [7:0]        cmd_angle,
    output logic              cmd_err,
    output logic [NUM_CH-1:0] servo,
    output logic              frame_tick,
    output logic [NUM_CH-1:0] settled
);

    localparam int CW = $clog2(PERIOD_CLKS);
    localparam logic [CW-1:0] LAST_CNT = CW'(PERIOD_CLKS - 1);
    localparam logic [CW-1:0] INIT_W   = CW'(MIN_CLKS + INIT_ANGLE * STEP_CLKS);
    localparam logic [CW:0]   SLEW_W   = (CW + 1)'(SLEW_CLKS);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ready_q;
    logic              err_q, err_d;
    logic              tick_q, tick_d;
    logic [NUM_CH-1:0] servo_q, servo_d;
    logic [NUM_CH-1:0] settled_q, settled_d;
    logic [CW-1:0]     tgt_q [NUM_CH];
    logic [CW-1:0]     tgt_d [NUM_CH];
    logic [CW-1:0]     cur_q [NUM_CH];
    logic [CW-1:0]     cur_d [NUM_CH];

    logic              accept;
    logic              ch_ok;
    logic              boundary;
    logic [7:0]        angle_c;
    logic [CW-1:0]     cmd_w;

    assign accept   = cmd_valid & ready_q;
    assign ch_ok    = (5'(cmd_ch) < 5'(NUM_CH));
    assign boundary = (cnt_q == LAST_CNT);
    assign angle_c  = (cmd_angle > 8'd180) ? 8'd180 : cmd_angle;
    assign cmd_w    = CW'(MIN_CLKS) + CW'(angle_c) * CW'(STEP_CLKS);

    always_comb begin
        cnt_d  = '0;
        tick_d = enable && (cnt_q == '0);
        err_d  = accept && !ch_ok;
        if (enable && !boundary) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Targets take writes immediately; current widths only move at the frame boundary,
    // using the targets as they stood before any write landing in the same cycle.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            logic [CW:0] up;
            logic [CW:0] tgt_plus;
            up           = {1'b0, cur_q[i]} + SLEW_W;
            tgt_plus     = {1'b0, tgt_q[i]} + SLEW_W;
            tgt_d[i]     = tgt_q[i];
            cur_d[i]     = cur_q[i];
            servo_d[i]   = enable && (cnt_q < cur_q[i]);
            settled_d[i] = (cur_q[i] == tgt_q[i]);
            if (accept && cmd_ch == 4'(i)) begin
                tgt_d[i] = cmd_w;
            end
            if (boundary) begin
                if (SLEW_CLKS == 0) begin
                    cur_d[i] = tgt_q[i];
                end else if (cur_q[i] < tgt_q[i]) begin
                    cur_d[i] = (up < {1'b0, tgt_q[i]}) ? up[CW-1:0] : tgt_q[i];
                end else if (cur_q[i] > tgt_q[i]) begin
                    cur_d[i] = ({1'b0, cur_q[i]} > tgt_plus) ? (cur_q[i] - SLEW_W[CW-1:0]) : tgt_q[i];
                end
            end
        end
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            tick_q    <= 1'b0;
            servo_q   <= '0;
            settled_q <= '1;
            for (int i = 0; i < NUM_CH; i++) begin
                tgt_q[i] <= INIT_W;
                cur_q[i] <= INIT_W;
            end
        end else begin
            cnt_q     <= cnt_d;
            ready_q   <= 1'b1;
            err_q     <= err_d;
            tick_q    <= tick_d;
            servo_q   <= servo_d;
            settled_q <= settled_d;
            for (int i = 0; i < NUM_CH; i++) begin
                tgt_q[i] <= tgt_d[i];
                cur_q[i] <= cur_d[i];
            end
        end
    end

    assign cmd_ready  = ready_q;
    assign cmd_err    = err_q;
    assign frame_tick = tick_q;
    assign servo      = servo_q;
    assign settled    = settled_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Scoreboard bench for servo_pwm_multi: two instances (slew-limited and jump-immediately)
// share stimulus; per-frame pulse widths and settled flags are checked against queued expectations.
module tb_servo_pwm_multi;

    localparam int P = 2000;

    logic       mclk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       cmd_valid;
    logic [3:0] cmd_ch;
    logic [7:0] cmd_angle;

    logic       ready1, err1, tick1;
    logic [3:0] servo1, settled1;
    logic       ready0, err0, tick0;
    logic [3:0] servo0, settled0;

    typedef struct packed {
        logic [3:0][15:0] w;
        logic [3:0]       st;
    } frameRec_t;

    frameRec_t q0[$];
    frameRec_t q1[$];
    int        errQ[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    frameRec_t curRec [2];
    bit        haveRec[2];
    int        hiCnt [2][4];
    int        frameNo[2];

    int rampDn[9] = '{495, 440, 385, 330, 275, 220, 165, 110, 100};
    int rampUp[9] = '{605, 660, 715, 770, 825, 880, 935, 990, 1000};

    servo_pwm_multi #(
        .NUM_CH(4), .PERIOD_CLKS(P), .MIN_CLKS(100), .STEP_CLKS(5),
        .SLEW_CLKS(55), .INIT_ANGLE(90)
    ) dutSlew (
        .mclk(mclk), .reset_n(reset_n), .enable(enable),
        .cmd_valid(cmd_valid), .cmd_ready(ready1), .cmd_ch(cmd_ch),
        .cmd_angle(cmd_angle), .cmd_err(err1), .servo(servo1),
        .frame_tick(tick1), .settled(settled1)
    );

    servo_pwm_multi #(
        .NUM_CH(4), .PERIOD_CLKS(P), .MIN_CLKS(100), .STEP_CLKS(5),
        .SLEW_CLKS(0), .INIT_ANGLE(90)
    ) dutJump (
        .mclk(mclk), .reset_n(reset_n), .enable(enable),
        .cmd_valid(cmd_valid), .cmd_ready(ready0), .cmd_ch(cmd_ch),
        .cmd_angle(cmd_angle), .cmd_err(err0), .servo(servo0),
        .frame_tick(tick0), .settled(settled0)
    );

    always #5 mclk = ~mclk;

    always @(posedge mclk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pushFrame(input int d, input int w0, input int w1, input int w2,
                             input int w3, input logic [3:0] st);
        frameRec_t r;
        r.w[0] = 16'(w0);
        r.w[1] = 16'(w1);
        r.w[2] = 16'(w2);
        r.w[3] = 16'(w3);
        r.st   = st;
        if (d == 0) q0.push_back(r);
        else        q1.push_back(r);
    endtask

    task automatic applyStimulus(input int ch, input int angle);
        @(negedge mclk);
        cmd_valid = 1'b1;
        cmd_ch    = 4'(ch);
        cmd_angle = 8'(angle);
        if (ch >= 4) errQ.push_back(cyc + 1);
        @(negedge mclk);
        cmd_valid = 1'b0;
    endtask

    task automatic waitTick();
        int n;
        n = 0;
        do begin
            @(negedge mclk);
            n++;
        end while (!tick1 && n < 2 * P + 10);
        if (!tick1) checkOutput("frame_tick timeout", int'(tick1), 1);
    endtask

    // Frame monitor: widths are counted tick-to-tick and compared when the next tick closes the frame.
    always @(negedge mclk) begin
        logic [3:0] sv;
        logic [3:0] st;
        logic       tk;
        for (int d = 0; d < 2; d++) begin
            sv = (d == 0) ? servo0   : servo1;
            st = (d == 0) ? settled0 : settled1;
            tk = (d == 0) ? tick0    : tick1;
            if (tk) begin
                if (haveRec[d]) begin
                    for (int i = 0; i < 4; i++)
                        checkOutput($sformatf("dut%0d frame%0d width ch%0d", d, frameNo[d], i),
                                    hiCnt[d][i], int'(curRec[d].w[i]));
                end
                haveRec[d] = 1'b0;
                if (d == 0 && q0.size() > 0) begin
                    curRec[d] = q0.pop_front();
                    haveRec[d] = 1'b1;
                end else if (d == 1 && q1.size() > 0) begin
                    curRec[d] = q1.pop_front();
                    haveRec[d] = 1'b1;
                end
                if (haveRec[d]) begin
                    frameNo[d]++;
                    checkOutput($sformatf("dut%0d frame%0d settled", d, frameNo[d]),
                                int'(st), int'(curRec[d].st));
                end
                for (int i = 0; i < 4; i++) hiCnt[d][i] = 0;
            end
            for (int i = 0; i < 4; i++) if (sv[i]) hiCnt[d][i]++;
        end
    end

    always @(negedge mclk) begin
        if (err1) begin
            if (errQ.size() == 0) checkOutput("unexpected cmd_err at cycle", cyc, -1);
            else                  checkOutput("cmd_err cycle", cyc, errQ.pop_front());
        end
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b0;
        cmd_valid = 1'b0;
        cmd_ch    = 4'd0;
        cmd_angle = 8'd0;
        repeat (3) @(negedge mclk);
        checkOutput("reset servo",      int'(servo1),   0);
        checkOutput("reset frame_tick", int'(tick1),    0);
        checkOutput("reset cmd_err",    int'(err1),     0);
        checkOutput("reset cmd_ready",  int'(ready1),   0);
        checkOutput("reset settled",    int'(settled1), 15);
        checkOutput("reset servo jump", int'(servo0),   0);
        checkOutput("reset settled jump", int'(settled0), 15);

        reset_n = 1'b1;
        @(negedge mclk);
        checkOutput("cmd_ready after reset", int'(ready1), 1);

        for (int f = 0; f < 3; f++) begin
            pushFrame(1, 550, 550, 550, 550, 4'b1111);
            pushFrame(0, 550, 550, 550, 550, 4'b1111);
        end
        enable = 1'b1;
        repeat (3) waitTick();

        repeat (10) @(negedge mclk);
        applyStimulus(1, 0);
        applyStimulus(2, 200);
        applyStimulus(3, 90);
        applyStimulus(5, 45);
        @(negedge mclk);
        checkOutput("settled after writes",      int'(settled1), 4'b1001);
        checkOutput("settled after writes jump", int'(settled0), 4'b1001);
        checkOutput("cmd_ready held",            int'(ready1),   1);

        for (int k = 0; k < 9; k++) begin
            pushFrame(1, 550, rampDn[k], rampUp[k], 550, (k == 8) ? 4'b1111 : 4'b1001);
            pushFrame(0, 550, 100, 1000, 550, 4'b1111);
        end
        repeat (9) waitTick();

        pushFrame(1, 550, 100, 1000, 550, 4'b1110);
        pushFrame(1, 605, 100, 1000, 550, 4'b1110);
        pushFrame(1, 660, 100, 1000, 550, 4'b1110);
        pushFrame(0, 550, 100, 1000, 550, 4'b1110);
        pushFrame(0, 1000, 100, 1000, 550, 4'b1111);
        pushFrame(0, 1000, 100, 1000, 550, 4'b1111);
        repeat (P - 2) @(posedge mclk);
        applyStimulus(0, 180);
        repeat (4) waitTick();

        repeat (20) @(negedge mclk);
        checkOutput("servo mid-pulse",      int'(servo1), 15);
        checkOutput("servo mid-pulse jump", int'(servo0), 15);
        enable = 1'b0;
        @(negedge mclk);
        checkOutput("servo after enable low",      int'(servo1), 0);
        checkOutput("servo after enable low jump", int'(servo0), 0);
        repeat (5) @(negedge mclk);

        pushFrame(1, 715, 100, 1000, 550, 4'b1110);
        pushFrame(0, 1000, 100, 1000, 550, 4'b1111);
        enable = 1'b1;
        @(negedge mclk);
        checkOutput("frame_tick after re-enable", int'(tick1), 1);
        waitTick();

        repeat (20) @(negedge mclk);
        checkOutput("servo before reset", int'(servo1), 15);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("servo async reset",      int'(servo1),   0);
        checkOutput("servo async reset jump", int'(servo0),   0);
        checkOutput("settled async reset",    int'(settled1), 15);
        checkOutput("cmd_ready async reset",  int'(ready1),   0);

        for (int f = 0; f < 2; f++) begin
            pushFrame(1, 550, 550, 550, 550, 4'b1111);
            pushFrame(0, 550, 550, 550, 550, 4'b1111);
        end
        @(negedge mclk);
        reset_n = 1'b1;
        repeat (3) waitTick();
        @(negedge mclk);

        checkOutput("frame queue leftover",      q1.size(),   0);
        checkOutput("frame queue leftover jump", q0.size(),   0);
        checkOutput("cmd_err queue leftover",    errQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
